// File: rtl/gru_gate_mac.sv
// Streaming signed Q.8 multiply-accumulate for one GRU gate pre-activation:
// y = bias + sum(w*x), rounded half-up and saturated. Optional macro GRU_MAC_PIPE_EN
// registers the product ahead of the accumulator (one extra cycle of latency).
module gru_gate_mac #(
    parameter int DATA_W  = 17,
    parameter int FRAC_W  = 8,
    parameter int ACC_W   = 40,
    parameter int MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_w,
    input  logic [DATA_W-1:0] in_x,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_sat,
    output logic              len_err
);

    localparam int CNT_W  = $clog2(MAX_LEN + 1);
    localparam int PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) <<< (FRAC_W - 1);
    localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_ROUND,
        S_OUT
    } state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic        [DATA_W-1:0]  y_q, y_d;
    logic                      sat_q, sat_d;
    logic                      ovalid_q, ovalid_d;
    logic                      lerr_q, lerr_d;

    logic                      in_fire;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   new_term;
    logic signed [ACC_W-1:0]   pend_term;
    logic                      pend_valid;
    logic        [CNT_W-1:0]   cnt_inc;
    logic                      term_beat;
    logic signed [ACC_W-1:0]   rnd_sum;
    logic signed [ACC_W-1:0]   rnd_shift;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign in_fire  = in_valid && in_ready;
    assign prod     = $signed(in_w) * $signed(in_x);
    assign bias_ext = ACC_W'($signed(bias)) <<< FRAC_W;

`ifdef GRU_MAC_PIPE_EN
    logic signed [PROD_W-1:0] prod_q;
    logic                     pv_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
        end else begin
            pv_q <= in_fire;
            if (in_fire) prod_q <= prod;
        end
    end

    // The registered product lands in the accumulator one cycle after its beat.
    assign pend_term  = pv_q ? ACC_W'(prod_q) : '0;
    assign pend_valid = pv_q;
    assign new_term   = '0;
`else
    assign pend_term  = '0;
    assign pend_valid = 1'b0;
    assign new_term   = ACC_W'(prod);
`endif

    assign cnt_inc   = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign term_beat = in_last || (cnt_inc == CNT_W'(MAX_LEN));
    assign rnd_sum   = acc_q + HALF;
    assign rnd_shift = rnd_sum >>> FRAC_W;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first so no latch is inferred.
        state_d  = state_q;
        acc_d    = acc_q + pend_term;
        cnt_d    = cnt_q;
        y_d      = y_q;
        sat_d    = sat_q;
        ovalid_d = ovalid_q;
        lerr_d   = lerr_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (in_fire) begin
                    acc_d   = (state_q == S_IDLE) ? bias_ext + new_term
                                                  : acc_q + pend_term + new_term;
                    cnt_d   = cnt_inc;
                    state_d = term_beat ? S_ROUND : S_ACCUM;
                    lerr_d  = term_beat && !in_last;
                end
            end
            S_ROUND: begin
                if (!pend_valid) begin
                    if (rnd_shift > Y_MAX) begin
                        y_d   = Y_MAX[DATA_W-1:0];
                        sat_d = 1'b1;
                    end else if (rnd_shift < Y_MIN) begin
                        y_d   = Y_MIN[DATA_W-1:0];
                        sat_d = 1'b1;
                    end else begin
                        y_d   = rnd_shift[DATA_W-1:0];
                        sat_d = 1'b0;
                    end
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                // out_valid rises one cycle after the result is captured.
                ovalid_d = 1'b1;
                if (ovalid_q && out_ready) begin
                    ovalid_d = 1'b0;
                    lerr_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            sat_q    <= 1'b0;
            ovalid_q <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            sat_q    <= sat_d;
            ovalid_q <= ovalid_d;
            lerr_q   <= lerr_d;
        end
    end

    assign out_valid = ovalid_q;
    assign out_y     = y_q;
    assign out_sat   = sat_q;
    assign len_err   = lerr_q;

endmodule

// File: tb/tb_gru_gate_mac.sv
// Directed bench for gru_gate_mac (MAX_LEN overridden to 4) with hand-computed
// Q.8 results; covers latency, rounding, saturation, backpressure, length error, reset.
module tb_gru_gate_mac;

    localparam int DW = 17;
`ifdef GRU_MAC_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] bias;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_w;
    logic [DW-1:0] in_x;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_y;
    logic          out_sat;
    logic          len_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [DW-1:0] vw [4];
    logic signed [DW-1:0] vx [4];

    gru_gate_mac #(.MAX_LEN(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_x      (in_x),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_sat   (out_sat),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sy(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n beats from vw/vx, then checks latency, result, optional hold, and handshake.
    task automatic do_vec(input string tag, input int n, input logic [DW-1:0] b,
                          input bit use_last, input longint ey, input bit es,
                          input bit el, input int hold);
        bias = b;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            in_valid = 1'b1;
            in_w     = vw[i];
            in_x     = vx[i];
            in_last  = use_last && (i == n - 1);
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            check({tag, "_in_ready_timeout"}, longint'(guard == 20), 0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int c = 1; c < LAT; c++) tick();
        check({tag, "_valid_early"}, longint'(out_valid), 0);
        tick();
        check({tag, "_valid"},    longint'(out_valid), 1);
        check({tag, "_y"},        sy(out_y), ey);
        check({tag, "_sat"},      longint'(out_sat), longint'(es));
        check({tag, "_len_err"},  longint'(len_err), longint'(el));
        check({tag, "_busy"},     longint'(in_ready), 0);
        in_valid = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, longint'(out_valid), 1);
            check({tag, "_hold_y"},     sy(out_y), ey);
            check({tag, "_hold_sat"},   longint'(out_sat), longint'(es));
            check({tag, "_hold_rdy"},   longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_done_valid"},   longint'(out_valid), 0);
        check({tag, "_done_ready"},   longint'(in_ready), 1);
        check({tag, "_done_len_err"}, longint'(len_err), 0);
    endtask

    initial begin
        reset     = 1'b0;
        bias      = '0;
        in_valid  = 1'b0;
        in_w      = '0;
        in_x      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vw[i] = '0;
            vx[i] = '0;
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();

        check("rst_valid",   longint'(out_valid), 0);
        check("rst_y",       sy(out_y), 0);
        check("rst_sat",     longint'(out_sat), 0);
        check("rst_len_err", longint'(len_err), 0);
        check("rst_ready",   longint'(in_ready), 1);

        // 1.0 * 3.1415
        vw[0] = 17'sd256; vx[0] = 17'sd804;
        do_vec("pi", 1, 17'sd0, 1'b1, 804, 1'b0, 1'b0, 0);

        // 0.5 + 1*1 + 2*(-1) = -0.5, held under backpressure
        vw[0] = 17'sd256; vx[0] = 17'sd256;
        vw[1] = 17'sd512; vx[1] = -17'sd256;
        do_vec("neg", 2, 17'sd128, 1'b1, -128, 1'b0, 1'b0, 5);

        // 0.5 LSB rounds up, -0.5 LSB rounds up to zero
        vw[0] = 17'sd128; vx[0] = 17'sd1;
        do_vec("rnd_pos", 1, 17'sd0, 1'b1, 1, 1'b0, 1'b0, 0);
        vw[0] = 17'sd128; vx[0] = -17'sd1;
        do_vec("rnd_neg", 1, 17'sd0, 1'b1, 0, 1'b0, 1'b0, 0);

        // Positive and negative saturation
        for (int i = 0; i < 4; i++) begin
            vw[i] = 17'sd65280;
            vx[i] = 17'sd65280;
        end
        do_vec("sat_pos", 4, 17'sd0, 1'b1, 65535, 1'b1, 1'b0, 0);
        vw[0] = -17'sd65536; vx[0] = 17'sd65280;
        vw[1] = -17'sd65536; vx[1] = 17'sd65280;
        do_vec("sat_neg", 2, 17'sd0, 1'b1, -65536, 1'b1, 1'b0, 0);

        // Vector cut off at MAX_LEN without in_last
        for (int i = 0; i < 4; i++) begin
            vw[i] = 17'sd256;
            vx[i] = 17'sd256;
        end
        do_vec("maxlen", 4, 17'sd0, 1'b0, 1024, 1'b0, 1'b1, 0);

        // Reset in the middle of a vector: no output, next vector clean
        bias     = 17'sd100;
        in_valid = 1'b1;
        in_w     = 17'sd256;
        in_x     = 17'sd256;
        in_last  = 1'b0;
        tick();
        tick();
        in_valid = 1'b0;
        reset    = 1'b0;
        #2;
        reset    = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            tick();
            check("midrst_valid", longint'(out_valid), 0);
        end
        check("midrst_ready", longint'(in_ready), 1);
        vw[0] = 17'sd256; vx[0] = 17'sd804;
        do_vec("after_rst", 1, 17'sd0, 1'b1, 804, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
